// File: rtl/dclk_rx_pkg.sv
// rtl/dclk_rx_pkg.sv - flit geometry and FSM encodings for the serial link receiver
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

package dclk_rx_pkg;
    localparam int FLIT_W      = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int RX_CNT_BITS = (FLIT_W > 1) ? $clog2(FLIT_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } rx_state_e;
endpackage

// File: rtl/dclk_rx_sync2.sv
// rtl/dclk_rx_sync2.sv - two-flop synchroniser (rx_sync2), reset to 0
module rx_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= 2'b00;
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];
endmodule

// File: rtl/dclk_rx.sv
// rtl/dclk_rx.sv - single-wire NoC link receiver; DCLK_RX_SYNC_EN adds an input synchroniser
module dclk_rx
    import dclk_rx_pkg::*;
#(
    parameter int routerid = -1,
    parameter     port     = "unknown"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic              channel_busy,
    output logic [FLIT_W-1:0] parallel_out,
    output logic              rx_valid,
    input  logic              rx_ack
);
    localparam logic [RX_CNT_BITS-1:0] LAST_BIT = RX_CNT_BITS'(FLIT_W - 1);

    logic                   serial_s;
    rx_state_e              state, next_state;
    logic [RX_CNT_BITS-1:0] cnt;
    logic [FLIT_W-1:0]      shift_reg, shift_next;

`ifdef DCLK_RX_SYNC_EN
    rx_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_in),
        .q     (serial_s)
    );
`else
    assign serial_s = serial_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (serial_s) next_state = RECV;
            RECV:    if (cnt == LAST_BIT) next_state = HOLD;
            HOLD:    if (rx_valid && rx_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_next      = shift_reg;
        shift_next[cnt] = serial_s;
    end

    // Frame end is count-based, so an all-zero payload is indistinguishable only by position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            shift_reg    <= '0;
            parallel_out <= '0;
            rx_valid     <= 1'b0;
            channel_busy <= 1'b0;
        end else begin
            channel_busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (serial_s) begin
                        cnt       <= '0;
                        shift_reg <= '0;
                    end
                end
                RECV: begin
                    shift_reg <= shift_next;
                    if (cnt == LAST_BIT) begin
                        cnt          <= '0;
                        parallel_out <= shift_next;
                        rx_valid     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (rx_valid && rx_ack) rx_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && state == HOLD && serial_s)
            $display("dclk_rx[%0d:%0s] warning: serial_in high while holding a flit", routerid, port);
    end
`endif
endmodule

// File: tb/tb_dclk_rx.sv
// tb/tb_dclk_rx.sv - randomized self-checking bench for dclk_rx
module tb_dclk_rx;
    import dclk_rx_pkg::*;

    localparam int W = FLIT_W;
`ifdef DCLK_RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         serial_in = 1'b0;
    logic         channel_busy;
    logic [W-1:0] parallel_out;
    logic         rx_valid;
    logic         rx_ack = 1'b0;

    int errors = 0;
    int checks = 0;

    dclk_rx #(.routerid(3), .port("west")) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .channel_busy (channel_busy),
        .parallel_out (parallel_out),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge; cycle 0 is the start-bit cycle.
    task automatic drive_frame(input logic [W-1:0] data);
        logic exp_busy;
        serial_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            exp_busy = (i >= SL);
            checks++;
            if (channel_busy !== exp_busy)
                $display("FAIL frame_busy cycle %0d: got %b want %b", i + 1, channel_busy, exp_busy);
            if (channel_busy !== exp_busy) errors++;
            checks++;
            if (rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL frame_valid cycle %0d: got %b want 0", i + 1, rx_valid);
            end
            serial_in = data[i];
            @(negedge clk);
        end
        serial_in = 1'b0;
    endtask

    task automatic wait_valid(input logic [W-1:0] exp, input string name);
        int n = W + 1;
        while (rx_valid !== 1'b1 && n < W + 1 + SL + 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != W + 1 + SL) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, W + 1 + SL);
        end
        checks++;
        if (parallel_out !== exp) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, parallel_out, exp);
        end
    endtask

    task automatic do_ack(input string name);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        checks++;
        if (rx_valid !== 1'b0 || channel_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_release: got valid=%b busy=%b want 0 0", name, rx_valid, channel_busy);
        end
    endtask

    task automatic idle_check(input int cycles, input string name);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0 || channel_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s idle: got valid=%b busy=%b want 0 0", name, rx_valid, channel_busy);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (parallel_out !== '0 || rx_valid !== 1'b0 || channel_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got po=%h valid=%b busy=%b want 0 0 0", parallel_out, rx_valid, channel_busy);
        end
        reset = 1'b0;
        idle_check(3, "post_reset");
    endtask

    task automatic test_single();
        drive_frame(12'hA5C);
        wait_valid(12'hA5C, "single");
        checks++;
        if (channel_busy !== 1'b1) begin
            errors++;
            $display("FAIL single busy_in_hold: got %b want 1", channel_busy);
        end
        do_ack("single");
    endtask

    task automatic test_zero_ones();
        logic [W-1:0] pats [2];
        pats[0] = '0;
        pats[1] = '1;
        rx_ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_frame(pats[k]);
            wait_valid(pats[k], "zero_ones");
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0 || channel_busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_ones one_cycle_hold: got valid=%b busy=%b want 0 0", rx_valid, channel_busy);
            end
            idle_check(2, "zero_ones_gap");
        end
        rx_ack = 1'b0;
    endtask

    task automatic test_hold_stable();
        logic [W-1:0] d = W'($urandom);
        drive_frame(d);
        wait_valid(d, "hold");
        for (int i = 0; i < 20; i++) begin
            serial_in = (i < 17) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || channel_busy !== 1'b1 || parallel_out !== d) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: got valid=%b busy=%b po=%h want 1 1 %h",
                         i, rx_valid, channel_busy, parallel_out, d);
            end
        end
        do_ack("hold");
    endtask

    task automatic test_ack_edge();
        logic [W-1:0] d1 = W'($urandom);
        logic [W-1:0] d2 = W'($urandom);
        rx_ack = 1'b1;
        idle_check(3, "ack_while_idle");
        rx_ack = 1'b0;
        drive_frame(d1);
        wait_valid(d1, "ack_edge");
        rx_ack = 1'b1;
        if (SL == 0) serial_in = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        serial_in = 1'b0;
        checks++;
        if (rx_valid !== 1'b0 || channel_busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_cycle_start: got valid=%b busy=%b want 0 0", rx_valid, channel_busy);
        end
        idle_check(SL + 4, "ack_cycle_start_ignored");
        drive_frame(d2);
        wait_valid(d2, "b2b_first");
        do_ack("b2b_first");
        d1 = W'($urandom);
        drive_frame(d1);
        wait_valid(d1, "b2b_second");
        do_ack("b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        int dly;
        for (int k = 0; k < 4; k++) begin
            d = W'($urandom);
            dly = $urandom_range(0, 5);
            drive_frame(d);
            wait_valid(d, "random");
            repeat (dly) @(negedge clk);
            checks++;
            if (parallel_out !== d || rx_valid !== 1'b1) begin
                errors++;
                $display("FAIL random hold: got po=%h valid=%b want %h 1", parallel_out, rx_valid, d);
            end
            do_ack("random");
        end
    endtask

    task automatic test_reset_mid();
        drive_frame(12'h9E7);
        wait_valid(12'h9E7, "pre_reset");
        do_ack("pre_reset");
        serial_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            serial_in = 1'($urandom);
            @(negedge clk);
        end
        checks++;
        if (channel_busy !== 1'b1 || parallel_out !== 12'h9E7) begin
            errors++;
            $display("FAIL mid_frame pre: got busy=%b po=%h want 1 9e7", channel_busy, parallel_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (parallel_out !== '0 || rx_valid !== 1'b0 || channel_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got po=%h valid=%b busy=%b want 0 0 0", parallel_out, rx_valid, channel_busy);
        end
        serial_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle_check(3, "after_reset");
        drive_frame(12'h3C1);
        wait_valid(12'h3C1, "after_reset");
        do_ack("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_ones();
        test_hold_stable();
        test_ack_edge();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end
endmodule
